// File: rtl/ext_loader_pkg.sv
// ---------------------------------------------------------------------------
// ext_loader_pkg
// Shared definitions for the external memory loader:
//   - default width/size constants for the loader parameters
//   - command opcode encodings carried on cmd_op
//   - loader FSM state encoding
// ---------------------------------------------------------------------------
package ext_loader_pkg;

    localparam int DEF_NUM_CORES      = 2;
    localparam int DEF_ADDR_W         = 9;
    localparam int DEF_DATA_W         = 16;
    localparam int DEF_TIMEOUT_CYCLES = 200000;

    typedef enum logic [1:0] {
        OP_LOAD_IRAM = 2'd0,
        OP_LOAD_DRAM = 2'd1,
        OP_READ_DRAM = 2'd2,
        OP_RUN       = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_OUT,
        ST_RUN
    } state_e;

endpackage

// File: rtl/ext_mem_loader.sv
// ---------------------------------------------------------------------------
// ext_mem_loader
// Command-driven loader that fills per-core IRAMs and a shared DRAM from a
// streaming write port, reads DRAM words back over a handshake, and starts
// the cores and waits for them to finish.
//
// Ports:
//   clock, rst_n            clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_op/core/base/len    opcode, target core, start address, word count
//   wr_valid/wr_ready/data  load-data stream
//   rd_valid/rd_ready/data  readback stream
//   iram_we                 per-core IRAM write strobe
//   dram_we, dram_re        DRAM write / read strobes
//   mem_addr, mem_wdata     shared memory bus (holds value between strobes)
//   dram_rdata              DRAM read data, valid one cycle after dram_re
//   core_start              run enable to all cores
//   cores_done              per-core completion flags
//   busy, err               not-idle indicator, sticky command error
//
// Build option: define LOADER_TIMEOUT_EN to add a RUN watchdog that gives up
// after TIMEOUT_CYCLES cycles, drops core_start and flags err. Without it RUN
// waits for cores_done indefinitely and TIMEOUT_CYCLES is unused.
// ---------------------------------------------------------------------------
module ext_mem_loader
    import ext_loader_pkg::*;
#(
    parameter int  NUM_CORES      = DEF_NUM_CORES,
    parameter int  ADDR_W         = DEF_ADDR_W,
    parameter int  DATA_W         = DEF_DATA_W,
    parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    // One spare code point so an out-of-range core index can be presented
    // and rejected even when NUM_CORES is a power of two.
    localparam int CORE_W         = $clog2(NUM_CORES + 1)
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CORE_W-1:0]    cmd_core,
    input  logic [ADDR_W-1:0]    cmd_base,
    input  logic [ADDR_W-1:0]    cmd_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_W-1:0]    rd_data,
    output logic [NUM_CORES-1:0] iram_we,
    output logic                 dram_we,
    output logic                 dram_re,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    dram_rdata,
    output logic                 core_start,
    input  logic [NUM_CORES-1:0] cores_done,
    output logic                 busy,
    output logic                 err
);

    state_e              state, next_state;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [ADDR_W-1:0]   rem_cnt;
    logic                load_iram_q;
    logic [CORE_W-1:0]   core_q;
    logic                core_bad;
    logic                tmo_hit;

    assign core_bad = (cmd_op == OP_LOAD_IRAM) && (int'(cmd_core) >= NUM_CORES);
    assign busy     = (state != ST_IDLE);

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts cycles spent in RUN with core_start high; the hit fires on the
    // edge that ends the TIMEOUT_CYCLES-th such cycle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (state == ST_RUN && core_start)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end

    assign tmo_hit = core_start && !(&cores_done) &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state and handshake outputs
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case below can leave one unassigned and infer a latch.
        next_state = state;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        rd_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_op == OP_RUN)
                        next_state = ST_RUN;
                    else if (core_bad)
                        next_state = ST_IDLE;
                    // Zero-length transfers of either kind drain through
                    // LOAD, which exits immediately with remaining == 0.
                    else if (cmd_op != OP_READ_DRAM || cmd_len == '0)
                        next_state = ST_LOAD;
                    else
                        next_state = ST_RD_REQ;
                end
            end
            ST_LOAD: begin
                wr_ready = (rem_cnt != '0);
                if (rem_cnt == '0)
                    next_state = ST_IDLE;
            end
            ST_RD_REQ:  next_state = ST_RD_WAIT;
            ST_RD_WAIT: next_state = ST_RD_OUT;
            ST_RD_OUT: begin
                rd_valid = 1'b1;
                if (rd_ready)
                    next_state = (rem_cnt != '0) ? ST_RD_REQ : ST_IDLE;
            end
            ST_RUN: begin
                // core_start drops one cycle before leaving RUN.
                if (!core_start || tmo_hit)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath: counters, registered strobes, memory bus, readback, flags
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt    <= '0;
            rem_cnt     <= '0;
            load_iram_q <= 1'b0;
            core_q      <= '0;
            iram_we     <= '0;
            dram_we     <= 1'b0;
            dram_re     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_data     <= '0;
            core_start  <= 1'b0;
            err         <= 1'b0;
        end else begin
            // Strobes are pulses: cleared every cycle unless re-armed below,
            // while mem_addr/mem_wdata simply keep their last value.
            iram_we <= '0;
            dram_we <= 1'b0;
            dram_re <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        err         <= core_bad;
                        addr_cnt    <= cmd_base;
                        rem_cnt     <= cmd_len;
                        load_iram_q <= (cmd_op == OP_LOAD_IRAM);
                        core_q      <= cmd_core;
                        core_start  <= (cmd_op == OP_RUN);
                        // Read strobe is armed on entry so it is high for
                        // exactly the RD_REQ cycle.
                        if (next_state == ST_RD_REQ) begin
                            dram_re  <= 1'b1;
                            mem_addr <= cmd_base;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_valid && wr_ready) begin
                        if (load_iram_q)
                            iram_we <= NUM_CORES'(1) << core_q;
                        else
                            dram_we <= 1'b1;
                        mem_addr  <= addr_cnt;
                        mem_wdata <= wr_data;
                        addr_cnt  <= addr_cnt + 1'b1;
                        rem_cnt   <= rem_cnt - 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    addr_cnt <= addr_cnt + 1'b1;
                    rem_cnt  <= rem_cnt - 1'b1;
                end
                ST_RD_WAIT: rd_data <= dram_rdata;
                ST_RD_OUT: begin
                    if (rd_ready && rem_cnt != '0) begin
                        dram_re  <= 1'b1;
                        mem_addr <= addr_cnt;
                    end
                end
                ST_RUN: begin
                    if (core_start && (&cores_done))
                        core_start <= 1'b0;
                    else if (tmo_hit) begin
                        core_start <= 1'b0;
                        err        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_ext_mem_loader
// Directed self-checking bench for ext_mem_loader (NUM_CORES=2, ADDR_W=9,
// DATA_W=16). One task per scenario; expected values are hand-computed.
// A negedge monitor logs write strobes and read requests; a small DRAM
// model returns 16'hC300 ^ address one cycle after dram_re.
// With LOADER_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=100
// and the watchdog scenario is run as well.
// ---------------------------------------------------------------------------
module tb_ext_mem_loader;
    import ext_loader_pkg::*;

    localparam int NC = 2;
    localparam int AW = 9;
    localparam int DW = 16;
`ifdef LOADER_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 200000;
`endif

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [1:0]    cmd_core = 2'd0;
    logic [AW-1:0] cmd_base = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [NC-1:0] iram_we;
    logic          dram_we;
    logic          dram_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] dram_rdata = '0;
    logic          core_start;
    logic [NC-1:0] cores_done = '0;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NC-1:0] iw;
        logic          dw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_ev_t;

    wr_ev_t        wr_log[$];
    logic [AW-1:0] re_log[$];
    int            excl_viol = 0;

    ext_mem_loader #(
        .NUM_CORES      (NC),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_core   (cmd_core),
        .cmd_base   (cmd_base),
        .cmd_len    (cmd_len),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .iram_we    (iram_we),
        .dram_we    (dram_we),
        .dram_re    (dram_re),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .dram_rdata (dram_rdata),
        .core_start (core_start),
        .cores_done (cores_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clock = ~clock;

    // DRAM model: data appears the cycle after the read strobe.
    always @(posedge clock)
        if (dram_re)
            dram_rdata <= 16'hC300 ^ {7'd0, mem_addr};

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (rst_n) begin
            if (iram_we != '0 || dram_we)
                wr_log.push_back({iram_we, dram_we, mem_addr, mem_wdata});
            if (dram_re)
                re_log.push_back(mem_addr);
            if ($countones({iram_we, dram_we, dram_re}) > 1)
                excl_viol++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] core,
                            input logic [AW-1:0] base, input logic [AW-1:0] len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_core  = core;
        cmd_base  = base;
        cmd_len   = len;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept_timeout cmd_ready=%b required=1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_accept_timeout wr_ready=%b required=1", wr_ready);
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_rd_valid();
        int n = 0;
        while (rd_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd_valid_timeout rd_valid=%b required=1", rd_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, err, core_start, rd_valid, wr_ready, iram_we, dram_we, dram_re} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=0",
                     {busy, err, core_start, rd_valid, wr_ready, iram_we, dram_we, dram_re});
        end
        checks++;
        if ({mem_addr, mem_wdata, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%0d wdata=%h rdata=%h required=0",
                     mem_addr, mem_wdata, rd_data);
        end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL idle_after_reset cmd_ready,busy=%b required=10", {cmd_ready, busy});
        end
    endtask

    task automatic test_load_iram();
        int ea[3] = '{1, 2, 3};
        int ed[3] = '{10, 20, 30};
        wr_log.delete();
        send_cmd(OP_LOAD_IRAM, 2'd1, 9'd1, 9'd3);
        checks++;
        if ({busy, cmd_ready, wr_ready} !== 3'b101) begin
            errors++;
            $display("FAIL load_iram_enter busy,cmd_ready,wr_ready=%b required=101",
                     {busy, cmd_ready, wr_ready});
        end
        send_word(16'd10);
        send_word(16'd20);
        send_word(16'd30);
        checks++;
        if ({iram_we, dram_we, mem_addr, mem_wdata, busy, wr_ready} !==
            {2'b10, 1'b0, 9'd3, 16'd30, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL load_iram_last iram_we=%b dram_we=%b addr=%0d data=%0d busy=%b wr_ready=%b required 10 0 3 30 1 0",
                     iram_we, dram_we, mem_addr, mem_wdata, busy, wr_ready);
        end
        tick();
        checks++;
        if ({iram_we, busy} !== 3'b000) begin
            errors++;
            $display("FAIL load_iram_idle iram_we=%b busy=%b required 00 0", iram_we, busy);
        end
        checks++;
        if (wr_log.size() != 3) begin
            errors++;
            $display("FAIL load_iram_count strobes=%0d required=3", wr_log.size());
        end
        for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
            checks++;
            if (wr_log[i] !== {2'b10, 1'b0, AW'(ea[i]), DW'(ed[i])}) begin
                errors++;
                $display("FAIL load_iram_word%0d iw=%b dw=%b addr=%0d data=%0d required iw=10 dw=0 addr=%0d data=%0d",
                         i, wr_log[i].iw, wr_log[i].dw, wr_log[i].a, wr_log[i].d, ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_load_dram_wrap();
        wr_log.delete();
        send_cmd(OP_LOAD_DRAM, 2'd0, 9'd511, 9'd2);
        send_word(16'd7);
        send_word(16'd8);
        tick();
        tick();
        checks++;
        if (wr_log.size() != 2) begin
            errors++;
            $display("FAIL dram_wrap_count strobes=%0d required=2", wr_log.size());
        end else begin
            checks++;
            if (wr_log[0] !== {2'b00, 1'b1, 9'd511, 16'd7}) begin
                errors++;
                $display("FAIL dram_wrap_word0 iw=%b dw=%b addr=%0d data=%0d required 00 1 511 7",
                         wr_log[0].iw, wr_log[0].dw, wr_log[0].a, wr_log[0].d);
            end
            checks++;
            if (wr_log[1] !== {2'b00, 1'b1, 9'd0, 16'd8}) begin
                errors++;
                $display("FAIL dram_wrap_word1 iw=%b dw=%b addr=%0d data=%0d required 00 1 0 8",
                         wr_log[1].iw, wr_log[1].dw, wr_log[1].a, wr_log[1].d);
            end
        end
    endtask

    task automatic test_read_dram();
        re_log.delete();
        rd_ready = 1'b0;
        send_cmd(OP_READ_DRAM, 2'd0, 9'd5, 9'd2);
        wait_rd_valid();
        checks++;
        if (rd_data !== 16'hC305 || re_log.size() != 1) begin
            errors++;
            $display("FAIL read0_data rd_data=%h reads=%0d required C305 1", rd_data, re_log.size());
        end else begin
            checks++;
            if (re_log[0] !== 9'd5) begin
                errors++;
                $display("FAIL read0_addr addr=%0d required=5", re_log[0]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 16'hC305 || re_log.size() != 1) begin
                errors++;
                $display("FAIL read0_hold%0d rd_valid=%b rd_data=%h reads=%0d required 1 C305 1",
                         i, rd_valid, rd_data, re_log.size());
            end
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++;
        if ({dram_re, rd_valid, mem_addr} !== {1'b1, 1'b0, 9'd6}) begin
            errors++;
            $display("FAIL read1_req dram_re=%b rd_valid=%b addr=%0d required 1 0 6",
                     dram_re, rd_valid, mem_addr);
        end
        wait_rd_valid();
        checks++;
        if (rd_data !== 16'hC306 || re_log.size() != 2) begin
            errors++;
            $display("FAIL read1_data rd_data=%h reads=%0d required C306 2", rd_data, re_log.size());
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++;
        if ({busy, rd_valid, dram_re} !== 3'b000) begin
            errors++;
            $display("FAIL read_end busy,rd_valid,dram_re=%b required=000", {busy, rd_valid, dram_re});
        end
    endtask

    task automatic test_run();
        int hi = 0;
        cores_done = 2'b01;
        checks++;
        if (core_start !== 1'b0) begin
            errors++;
            $display("FAIL run_pre core_start=%b required=0", core_start);
        end
        send_cmd(OP_RUN, 2'd0, 9'd0, 9'd0);
        for (int i = 0; i < 50; i++) begin
            if (core_start === 1'b1)
                hi++;
            if (i == 49)
                cores_done = 2'b11;
            tick();
        end
        checks++;
        if (hi != 50) begin
            errors++;
            $display("FAIL run_high_cycles got=%0d required=50", hi);
        end
        checks++;
        if ({core_start, busy} !== 2'b01) begin
            errors++;
            $display("FAIL run_stop core_start,busy=%b required=01", {core_start, busy});
        end
        tick();
        checks++;
        if ({core_start, busy} !== 2'b00) begin
            errors++;
            $display("FAIL run_idle core_start,busy=%b required=00", {core_start, busy});
        end
        cores_done = 2'b00;
    endtask

    task automatic test_bad_core_and_zero_len();
        wr_log.delete();
        re_log.delete();
        send_cmd(OP_LOAD_IRAM, 2'd2, 9'd0, 9'd1);
        checks++;
        if ({err, busy, cmd_ready} !== 3'b101) begin
            errors++;
            $display("FAIL bad_core err,busy,cmd_ready=%b required=101", {err, busy, cmd_ready});
        end
        wr_valid = 1'b1;
        wr_data  = 16'hDEAD;
        repeat (3) tick();
        wr_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || wr_log.size() != 0) begin
            errors++;
            $display("FAIL bad_core_sticky err=%b strobes=%0d required 1 0", err, wr_log.size());
        end
        send_cmd(OP_LOAD_DRAM, 2'd0, 9'd20, 9'd0);
        checks++;
        if ({err, wr_ready} !== 2'b00) begin
            errors++;
            $display("FAIL zero_len_load err,wr_ready=%b required=00", {err, wr_ready});
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_load_idle busy=%b required=0", busy);
        end
        send_cmd(OP_READ_DRAM, 2'd0, 9'd20, 9'd0);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_read_valid rd_valid=%b required=0", rd_valid);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || re_log.size() != 0 || wr_log.size() != 0) begin
            errors++;
            $display("FAIL zero_len_read busy=%b rd_valid=%b reads=%0d writes=%0d required 0 0 0 0",
                     busy, rd_valid, re_log.size(), wr_log.size());
        end
    endtask

    task automatic test_reset_mid_load();
        send_cmd(OP_LOAD_IRAM, 2'd0, 9'd100, 9'd3);
        send_word(16'h1111);
        checks++;
        if ({iram_we, mem_addr, mem_wdata} !== {2'b01, 9'd100, 16'h1111}) begin
            errors++;
            $display("FAIL midload_word0 iram_we=%b addr=%0d data=%h required 01 100 1111",
                     iram_we, mem_addr, mem_wdata);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({iram_we, dram_we, dram_re, core_start, rd_valid, wr_ready, busy, err} !== 9'd0 ||
            {mem_addr, mem_wdata, rd_data} !== '0) begin
            errors++;
            $display("FAIL midload_async_reset ctrl=%b addr=%0d wdata=%h rdata=%h required all 0",
                     {iram_we, dram_we, dram_re, core_start, rd_valid, wr_ready, busy, err},
                     mem_addr, mem_wdata, rd_data);
        end
        wr_log.delete();
        wr_valid = 1'b1;
        wr_data  = 16'h2222;
        #3 rst_n = 1'b1;
        repeat (8) tick();
        checks++;
        if (wr_log.size() != 0 || busy !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL midload_abandon strobes=%0d busy=%b wr_ready=%b required 0 0 0",
                     wr_log.size(), busy, wr_ready);
        end
        wr_valid = 1'b0;
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int hi = 0;
        int n  = 0;
        cores_done = 2'b00;
        send_cmd(OP_RUN, 2'd0, 9'd0, 9'd0);
        while (core_start === 1'b1 && n < 300) begin
            hi++;
            tick();
            n++;
        end
        checks++;
        if (hi != 100) begin
            errors++;
            $display("FAIL timeout_cycles got=%0d required=100", hi);
        end
        checks++;
        if ({core_start, err, busy} !== 3'b010) begin
            errors++;
            $display("FAIL timeout_state core_start,err,busy=%b required=010", {core_start, err, busy});
        end
    endtask
`endif

    task automatic test_exclusive_strobes();
        checks++;
        if (excl_viol != 0) begin
            errors++;
            $display("FAIL strobe_exclusive overlapping_cycles=%0d required=0", excl_viol);
        end
    endtask

    initial begin
        test_reset();
        test_load_iram();
        test_load_dram_wrap();
        test_read_dram();
        test_run();
        test_bad_core_and_zero_len();
        test_reset_mid_load();
`ifdef LOADER_TIMEOUT_EN
        test_timeout();
`endif
        test_exclusive_strobes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
